// File: rtl/rtime_pkg.sv
// rtime_pkg: shared types and helpers for the reaction-time round controller.
//   rtime_state_t : round controller states
//   bcd_digit_t   : one BCD digit
//   bcd4_t        : four packed BCD digits, [3] = thousands ... [0] = units
//   BCD_MAX       : largest four-digit BCD value
//   to_bcd4       : converts a binary constant into bcd4_t (used for parameters)
//   bcd4_inc      : decimal increment of a bcd4_t value, wrapping 9999 -> 0000
package rtime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    TIMING,
    SHOW,
    EARLY,
    TIMEOUT
  } rtime_state_t;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd4_t;

  localparam bcd4_t BCD_MAX = 16'h9999;

  function automatic bcd4_t to_bcd4(input int unsigned value);
    bcd4_t       r;
    int unsigned v;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[i] = bcd_digit_t'(v % 10);
      v    = v / 10;
    end
    return r;
  endfunction

  // Ripple a carry up from the units digit; a digit at 9 rolls to 0 and
  // passes the carry on.
  function automatic bcd4_t bcd4_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rtime_ctrl_bcd_counter4.sv
// bcd_counter4: four-digit BCD up-counter that saturates at MAX_VAL.
//   clk    : system clock
//   rst    : synchronous active-high reset, clears q
//   clr    : synchronous clear, clears q
//   inc    : count up by one; ignored while at_max
//   q      : current count, four BCD digits
//   at_max : q equals MAX_VAL
module bcd_counter4
  import rtime_pkg::*;
#(
  parameter bcd4_t MAX_VAL = BCD_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  bcd4_t count;

  assign q      = count;
  assign at_max = (count == MAX_VAL);

  // Clear wins over increment; increments stop once the ceiling is reached
  // so the count can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= bcd4_inc(count);
    end
  end

endmodule

// File: rtl/rtime_ctrl.sv
// rtime_ctrl: round controller and reaction-time measurer.
// A start press requests a random wait from rcounter (start_rwait), the end
// of that wait lights the cue LED and milliseconds are counted in BCD until
// the stop press. Early presses and timeouts are flagged.
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : single-cycle debounced button pulses
//   r_waitdone   : end of random wait from rcounter
//   start_rwait  : high for the whole WAIT state
//   led          : reaction cue, high in TIMING
//   time_bcd     : elapsed ms, four BCD digits
//   result_valid : high in SHOW, EARLY, TIMEOUT
//   early        : high in EARLY
//   timeout      : high in TIMEOUT
//   best_bcd     : best SHOW time since reset (only with RTIME_BEST_EN defined)
// Optional feature macro: RTIME_BEST_EN.
module rtime_ctrl
  import rtime_pkg::*;
#(
  parameter int CLKS_PER_MS = 100000,
  parameter int MAX_MS      = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        r_waitdone,
  output logic        start_rwait,
  output logic        led,
  output logic [15:0] time_bcd,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
`ifdef RTIME_BEST_EN
  ,
  output logic [15:0] best_bcd
`endif
);

  localparam int    PW      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam bcd4_t MAX_BCD = to_bcd4(MAX_MS);

  rtime_state_t  state;
  rtime_state_t  next_state;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          at_max;

  assign tick = (state == TIMING) && (prescaler == PW'(CLKS_PER_MS - 1));

  // The prescaler only runs in TIMING and sits at zero everywhere else, so
  // every entry into TIMING starts a fresh millisecond.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (state != TIMING || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, counter control and state-decoded outputs. Outputs depend
  // only on the registered state; inputs only steer next_state and the counter.
  always_comb begin
    next_state   = state;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    start_rwait  = 1'b0;
    led          = 1'b0;
    result_valid = 1'b0;
    early        = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = WAIT;
          cnt_clr    = 1'b1;
        end
      end
      WAIT: begin
        start_rwait = 1'b1;
        if (stop) begin
          next_state = EARLY;
          cnt_clr    = 1'b1;
        end else if (r_waitdone) begin
          next_state = TIMING;
        end
      end
      TIMING: begin
        led = 1'b1;
        // A stop in the same cycle as a tick discards the tick.
        if (stop) begin
          next_state = SHOW;
        end else if (tick) begin
          if (at_max) begin
            next_state = TIMEOUT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      SHOW, EARLY, TIMEOUT: begin
        result_valid = 1'b1;
        early        = (state == EARLY);
        timeout      = (state == TIMEOUT);
        if (start) begin
          next_state = WAIT;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  bcd_counter4 #(
    .MAX_VAL(MAX_BCD)
  ) u_time (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (time_bcd),
    .at_max(at_max)
  );

`ifdef RTIME_BEST_EN
  // time_bcd is frozen throughout SHOW, so comparing every SHOW cycle gives
  // the same result as comparing once on entry. Packed BCD orders the same
  // way as the decimal value it encodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_bcd <= BCD_MAX;
    end else if (state == SHOW && time_bcd < best_bcd) begin
      best_bcd <= time_bcd;
    end
  end
`endif

endmodule

// File: tb/tb_rtime_ctrl.sv
// tb_rtime_ctrl: self-checking bench for rtime_ctrl with CLKS_PER_MS = 4.
// Each round's expected result is pushed into a queue when the deciding
// stimulus is issued; a monitor pops and compares whenever result_valid rises.
// Expected times come from the elapsed cycle count: a stop sampled N edges
// after TIMING entry has seen floor((N-1)/4) millisecond ticks.
// Define RTIME_BEST_EN to also check best_bcd.
module tb_rtime_ctrl;

  localparam int CLKS  = 4;
  localparam int MAXMS = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        r_waitdone = 1'b0;
  logic        start_rwait;
  logic        led;
  logic [15:0] time_bcd;
  logic        result_valid;
  logic        early;
  logic        timeout;
`ifdef RTIME_BEST_EN
  logic [15:0] best_bcd;
`endif

  rtime_ctrl #(
    .CLKS_PER_MS(CLKS),
    .MAX_MS     (MAXMS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .r_waitdone  (r_waitdone),
    .start_rwait (start_rwait),
    .led         (led),
    .time_bcd    (time_bcd),
    .result_valid(result_valid),
    .early       (early),
    .timeout     (timeout)
`ifdef RTIME_BEST_EN
    ,
    .best_bcd    (best_bcd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_early;
    bit          is_timeout;
    logic [15:0] t;
    logic [15:0] best;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   best_ms  = 9999;

  function automatic logic [15:0] ms_to_bcd(input int ms);
    return {4'(ms / 1000), 4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_result(input bit e, input bit to, input int ms);
    exp_t x;
    if (!e && !to && ms < best_ms) best_ms = ms;
    x.is_early   = e;
    x.is_timeout = to;
    x.t          = ms_to_bcd(ms);
    x.best       = ms_to_bcd(best_ms);
    sb.push_back(x);
  endtask

  // mode 0: stop n edges after cue; 1: stop n edges after start, before the
  // wait ends; 2: stop and r_waitdone together; 3: never stop (timeout).
  // w is the edge count from start to r_waitdone.
  task automatic applyStimulus(input int mode, input int w, input int n);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("start_rwait_latency", {31'd0, start_rwait}, 1);
    checkOutput("time_clear_on_start", {16'd0, time_bcd}, 0);
    checkOutput("flags_drop_on_start", {29'd0, result_valid, early, timeout}, 0);
    case (mode)
      1: begin
        step(n - 1);
        stop = 1'b1;
        push_result(1'b1, 1'b0, 0);
        step(1);
        stop = 1'b0;
        checkOutput("early_rwait_low", {31'd0, start_rwait}, 0);
        checkOutput("early_led_low", {31'd0, led}, 0);
      end
      2: begin
        step(w - 1);
        stop       = 1'b1;
        r_waitdone = 1'b1;
        push_result(1'b1, 1'b0, 0);
        step(1);
        stop       = 1'b0;
        r_waitdone = 1'b0;
        checkOutput("tie_early_flag", {31'd0, early}, 1);
        checkOutput("tie_led_low", {31'd0, led}, 0);
      end
      default: begin
        step(w - 1);
        r_waitdone = 1'b1;
        step(1);
        r_waitdone = 1'b0;
        checkOutput("led_latency", {31'd0, led}, 1);
        checkOutput("rwait_drop_timing", {31'd0, start_rwait}, 0);
        if (mode == 0) begin
          step(n - 1);
          stop = 1'b1;
          push_result(1'b0, 1'b0, ((n - 1) / CLKS > MAXMS) ? MAXMS : (n - 1) / CLKS);
          step(1);
          stop = 1'b0;
          checkOutput("stop_latency", {31'd0, result_valid}, 1);
          checkOutput("show_led_low", {31'd0, led}, 0);
        end else begin
          int          cnt;
          bit          seen_roll;
          logic [15:0] prev;
          cnt       = 0;
          seen_roll = 1'b0;
          prev      = time_bcd;
          push_result(1'b0, 1'b1, MAXMS);
          while (!timeout && cnt < CLKS * (MAXMS + 1) + 50) begin
            step(1);
            cnt++;
            if (prev == 16'h0999 && time_bcd != prev) begin
              seen_roll = 1'b1;
              checkOutput("rollover_0999_1000", {16'd0, time_bcd}, 32'h1000);
            end
            prev = time_bcd;
          end
          checkOutput("rollover_seen", {31'd0, seen_roll}, 1);
          checkOutput("timeout_latency", cnt, CLKS * (MAXMS + 1));
          checkOutput("timeout_time_sat", {16'd0, time_bcd}, 32'h9999);
          checkOutput("timeout_led_low", {31'd0, led}, 0);
        end
      end
    endcase
    step(3);
  endtask

  // Monitor: compares each new result against the oldest expectation.
  initial begin
    exp_t e;
    logic prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("result_time", {16'd0, time_bcd}, {16'd0, e.t});
          checkOutput("result_early", {31'd0, early}, {31'd0, e.is_early});
          checkOutput("result_timeout", {31'd0, timeout}, {31'd0, e.is_timeout});
`ifdef RTIME_BEST_EN
          @(negedge clk);
          checkOutput("best_bcd", {16'd0, best_bcd}, {16'd0, e.best});
`endif
        end
      end
      prev_rv = result_valid;
    end
  end

  initial begin
    int mode;
    int w;
    int n;
    int r;
    bit found;

    $display("[TB] reset sequence");
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checkOutput("reset_outputs", {26'd0, start_rwait, led, result_valid, early, timeout, 1'b0}, 0);
    checkOutput("reset_time", {16'd0, time_bcd}, 0);
`ifdef RTIME_BEST_EN
    checkOutput("reset_best", {16'd0, best_bcd}, 32'h9999);
`endif
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    checkOutput("idle_ignores_stop", {29'd0, start_rwait, led, result_valid}, 0);

    applyStimulus(0, 5, 41);
    applyStimulus(0, 3, 29);
    applyStimulus(0, 4, 49);
    applyStimulus(1, 4, 2);
    applyStimulus(2, 3, 0);
    applyStimulus(3, 2, 0);

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(2, 8);
      if (r < 6) begin
        mode = 0;
        n    = $urandom_range(1, 60);
      end else if (r < 8) begin
        mode = 1;
        n    = $urandom_range(1, w - 1);
      end else begin
        mode = 2;
        n    = 0;
      end
      applyStimulus(mode, w, n);
    end

    // Reset in the middle of a timing run.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    r_waitdone = 1'b1;
    step(1);
    r_waitdone = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1);
      if (time_bcd == 16'h0123) found = 1'b1;
    end
    checkOutput("reach_0123", {31'd0, found}, 1);
    rst     = 1'b1;
    best_ms = 9999;
    step(1);
    rst = 1'b0;
    checkOutput("midreset_led", {31'd0, led}, 0);
    checkOutput("midreset_rwait", {31'd0, start_rwait}, 0);
    checkOutput("midreset_time", {16'd0, time_bcd}, 0);
    checkOutput("midreset_flags", {29'd0, result_valid, early, timeout}, 0);
`ifdef RTIME_BEST_EN
    checkOutput("midreset_best", {16'd0, best_bcd}, 32'h9999);
`endif
    step(3);
    checkOutput("scoreboard_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
